// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared lane-count, select-width and lane-mask type for the
//               registered 1:8 demultiplexer and its select decoder.
//               Contents:
//                 NUM_LANES     - number of output lanes (8)
//                 SEL_WIDTH     - width of the lane index (3)
//                 lane_onehot_t - one bit per lane
//                 lane_onehot() - index-to-one-hot helper
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

  localparam int NUM_LANES = 8;
  localparam int SEL_WIDTH = 3;

  typedef logic [NUM_LANES-1:0] lane_onehot_t;

  // Every 3-bit index maps to exactly one lane, so no range check is needed.
  function automatic lane_onehot_t lane_onehot(input logic [SEL_WIDTH-1:0] sel);
    return lane_onehot_t'(1) << sel;
  endfunction

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_sel_decoder.sv
`default_nettype none
// ============================================================================
// Module      : demux_sel_decoder
// Description : Combinational 3-to-8 decoder with enable. Its output is the
//               per-lane write strobe for the data registers and the
//               next-state value of the lane-valid register.
// Ports       :
//   i_enable    in   1          1 = decode i_sel, 0 = all-zero mask
//   i_sel       in   SEL_WIDTH  lane index 0..7
//   o_lane_mask out  NUM_LANES  one-hot (or zero) lane mask
// Revision    : 1.0 - initial release
// ============================================================================
module demux_sel_decoder
  import demux_pkg::*;
(
  input  logic                 i_enable,
  input  logic [SEL_WIDTH-1:0] i_sel,
  output lane_onehot_t         o_lane_mask
);

  always_comb begin
    o_lane_mask = '0;
    if (i_enable) begin
      o_lane_mask = lane_onehot(i_sel);
    end
  end

endmodule : demux_sel_decoder
`default_nettype wire

// File: rtl/demux_1_8_registered.sv
`default_nettype none
// ============================================================================
// Module      : demux_1_8_registered
// Description : 1:8 demultiplexer with registered outputs. Data_In is routed
//               to the lane chosen by Select_In when Enable_In is high; all
//               outputs change only on the rising clock edge (one cycle of
//               latency) or on asynchronous reset.
// Parameters  :
//   DATA_WIDTH      width of Data_In and of each lane output
//   HOLD_UNSELECTED 0 = unwritten lanes clear to zero each edge
//                   1 = unwritten lanes keep their last value
// Ports       :
//   Clk_In      in   1           system clock, rising edge
//   Reset_N_In  in   1           asynchronous active-low reset
//   Enable_In   in   1           1 = write the selected lane this edge
//   Data_In     in   DATA_WIDTH  data to route
//   Select_In   in   3           lane index 0..7
//   Data_k_Out  out  DATA_WIDTH  registered lane outputs, k = 0..7
//   Valid_Out   out  8           one-hot: bit k = lane k written last edge
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1_8_registered
  import demux_pkg::*;
#(
  parameter int DATA_WIDTH      = 1,
  parameter bit HOLD_UNSELECTED = 1'b0
) (
  input  logic                  Clk_In,
  input  logic                  Reset_N_In,
  input  logic                  Enable_In,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic [SEL_WIDTH-1:0]  Select_In,
  output logic [DATA_WIDTH-1:0] Data_0_Out,
  output logic [DATA_WIDTH-1:0] Data_1_Out,
  output logic [DATA_WIDTH-1:0] Data_2_Out,
  output logic [DATA_WIDTH-1:0] Data_3_Out,
  output logic [DATA_WIDTH-1:0] Data_4_Out,
  output logic [DATA_WIDTH-1:0] Data_5_Out,
  output logic [DATA_WIDTH-1:0] Data_6_Out,
  output logic [DATA_WIDTH-1:0] Data_7_Out,
  output lane_onehot_t          Valid_Out
);

  lane_onehot_t          w_lane_mask;
  logic [DATA_WIDTH-1:0] r_lane_data [NUM_LANES];
  lane_onehot_t          r_valid;

  demux_sel_decoder u_sel_decoder (
    .i_enable    (Enable_In),
    .i_sel       (Select_In),
    .o_lane_mask (w_lane_mask)
  );

  // One register bank for all lanes; the decoder mask is the write strobe.
  // A lane that is not written either clears or holds depending on
  // HOLD_UNSELECTED, which also covers the Enable_In=0 case (mask all-zero).
  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        r_lane_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (w_lane_mask[k]) begin
          r_lane_data[k] <= Data_In;
        end else if (!HOLD_UNSELECTED) begin
          r_lane_data[k] <= '0;
        end
      end
    end
  end

  // Valid marks a write, independent of the data value, so it follows the
  // mask directly and is one-hot or zero by construction.
  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_lane_mask;
    end
  end

  assign Data_0_Out = r_lane_data[0];
  assign Data_1_Out = r_lane_data[1];
  assign Data_2_Out = r_lane_data[2];
  assign Data_3_Out = r_lane_data[3];
  assign Data_4_Out = r_lane_data[4];
  assign Data_5_Out = r_lane_data[5];
  assign Data_6_Out = r_lane_data[6];
  assign Data_7_Out = r_lane_data[7];
  assign Valid_Out  = r_valid;

endmodule : demux_1_8_registered
`default_nettype wire

// File: tb/tb_demux_1_8_registered.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1_8_registered
// Description : Directed bench for demux_1_8_registered. Two instances share
//               stimulus: u_a (DATA_WIDTH=1, clear mode) and u_b
//               (DATA_WIDTH=8, hold mode). Instance u_a sees bit 0 of the
//               8-bit stimulus data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1_8_registered;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] din;
  logic [2:0] sel;

  logic [7:0] a_out;
  logic [7:0] a_valid;
  logic [7:0] b_out [8];
  logic [7:0] b_valid;

  int total;
  int passed;

  // Reference model state
  logic [7:0] ma;
  logic [7:0] mb [8];
  logic [7:0] mva;
  logic [7:0] mvb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  demux_1_8_registered #(.DATA_WIDTH(1), .HOLD_UNSELECTED(1'b0)) u_a (
    .Clk_In     (clk),
    .Reset_N_In (rst_n),
    .Enable_In  (en),
    .Data_In    (din[0]),
    .Select_In  (sel),
    .Data_0_Out (a_out[0]),
    .Data_1_Out (a_out[1]),
    .Data_2_Out (a_out[2]),
    .Data_3_Out (a_out[3]),
    .Data_4_Out (a_out[4]),
    .Data_5_Out (a_out[5]),
    .Data_6_Out (a_out[6]),
    .Data_7_Out (a_out[7]),
    .Valid_Out  (a_valid)
  );

  demux_1_8_registered #(.DATA_WIDTH(8), .HOLD_UNSELECTED(1'b1)) u_b (
    .Clk_In     (clk),
    .Reset_N_In (rst_n),
    .Enable_In  (en),
    .Data_In    (din),
    .Select_In  (sel),
    .Data_0_Out (b_out[0]),
    .Data_1_Out (b_out[1]),
    .Data_2_Out (b_out[2]),
    .Data_3_Out (b_out[3]),
    .Data_4_Out (b_out[4]),
    .Data_5_Out (b_out[5]),
    .Data_6_Out (b_out[6]),
    .Data_7_Out (b_out[7]),
    .Valid_Out  (b_valid)
  );

  function automatic logic [63:0] b_bus();
    return {b_out[7], b_out[6], b_out[5], b_out[4],
            b_out[3], b_out[2], b_out[1], b_out[0]};
  endfunction

  function automatic logic [63:0] mb_bus();
    return {mb[7], mb[6], mb[5], mb[4], mb[3], mb[2], mb[1], mb[0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ma  = 8'h00;
    mva = 8'h00;
    mvb = 8'h00;
    for (int k = 0; k < 8; k++) mb[k] = 8'h00;
  endtask

  // Apply inputs just after an edge, advance through the next edge, update
  // the model and land 1 ns after that edge for sampling.
  task automatic cycle(input logic e, input logic [2:0] s, input logic [7:0] d);
    en  = e;
    sel = s;
    din = d;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      if (e && (s == 3'(k))) begin
        ma[k] = d[0];
        mb[k] = d;
      end else begin
        ma[k] = 1'b0;
      end
    end
    mva = e ? (8'h01 << s) : 8'h00;
    mvb = mva;
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_a_data"},  {56'h0, a_out},   {56'h0, ma});
    check({tag, "_a_valid"}, {56'h0, a_valid}, {56'h0, mva});
    check({tag, "_b_data"},  b_bus(),          mb_bus());
    check({tag, "_b_valid"}, {56'h0, b_valid}, {56'h0, mvb});
  endtask

  initial begin
    total  = 0;
    passed = 0;
    model_reset();

    // Reset held with live inputs and a running clock
    rst_n = 1'b0;
    en    = 1'b1;
    din   = 8'hFF;
    sel   = 3'd5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_a_data",  {56'h0, a_out},   64'h0);
      check("rst_a_valid", {56'h0, a_valid}, 64'h0);
      check("rst_b_data",  b_bus(),          64'h0);
      check("rst_b_valid", {56'h0, b_valid}, 64'h0);
    end
    rst_n = 1'b1;

    // Latency: new inputs do not show before the edge
    en  = 1'b1;
    sel = 3'd0;
    din = 8'h01;
    #3;
    check("latency_pre_edge_a_valid", {56'h0, a_valid}, 64'h0);
    check("latency_pre_edge_b_data",  b_bus(),          64'h0);

    // Lane sweep
    for (int s = 0; s < 8; s++) begin
      cycle(1'b1, 3'(s), 8'h01);
      check("sweep_a_data",  {56'h0, a_out},   {56'h0, 8'h01 << s});
      check("sweep_a_valid", {56'h0, a_valid}, {56'h0, 8'h01 << s});
      check("sweep_b_valid", {56'h0, b_valid}, {56'h0, 8'h01 << s});
    end
    check("sweep_b_hold_all", b_bus(), 64'h0101010101010101);

    // Zero data still raises valid
    cycle(1'b1, 3'd3, 8'h00);
    check("zero_a_data",  {56'h0, a_out},   64'h0);
    check("zero_a_valid", {56'h0, a_valid}, 64'h08);
    check("zero_b_data",  b_bus(),          64'h0101010100010101);
    check("zero_b_valid", {56'h0, b_valid}, 64'h08);

    // Write lane 6, then disable
    cycle(1'b1, 3'd6, 8'h01);
    check("l6_a_data",  {56'h0, a_out},   64'h40);
    check("l6_a_valid", {56'h0, a_valid}, 64'h40);
    cycle(1'b0, 3'd6, 8'h01);
    check("dis_a_data",  {56'h0, a_out},   64'h0);
    check("dis_a_valid", {56'h0, a_valid}, 64'h0);
    check("dis_b_lane6", {56'h0, b_out[6]}, 64'h01);
    check("dis_b_data",  b_bus(),          64'h0101010100010101);
    check("dis_b_valid", {56'h0, b_valid}, 64'h0);

    // Select change between edges has no effect
    sel = 3'd1;
    en  = 1'b1;
    #2;
    check("sel_between_edges_a_valid", {56'h0, a_valid}, 64'h0);
    check("sel_between_edges_b_data",  b_bus(),          64'h0101010100010101);

    // Mid-cycle asynchronous reset
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_a_data",  {56'h0, a_out},   64'h0);
    check("async_rst_a_valid", {56'h0, a_valid}, 64'h0);
    check("async_rst_b_data",  b_bus(),          64'h0);
    check("async_rst_b_valid", {56'h0, b_valid}, 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Hold mode: two lanes coexist
    cycle(1'b1, 3'd2, 8'hA5);
    check("hold1_b_data",  b_bus(),          64'h0000000000A50000);
    check("hold1_a_data",  {56'h0, a_out},   64'h04);
    check("hold1_b_valid", {56'h0, b_valid}, 64'h04);
    cycle(1'b1, 3'd7, 8'h3C);
    check("hold2_b_data",  b_bus(),          64'h3C00000000A50000);
    check("hold2_b_valid", {56'h0, b_valid}, 64'h80);
    check("hold2_a_data",  {56'h0, a_out},   64'h0);
    check("hold2_a_valid", {56'h0, a_valid}, 64'h80);

    // Random writes against the model
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      check_model("rand");
      check("rand_onehot_a", 64'($countones(a_valid)), 64'd1);
      check("rand_onehot_b", 64'($countones(b_valid)), 64'd1);
    end

    // Disable after random traffic
    cycle(1'b0, 3'd4, 8'h77);
    check_model("final_dis");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_demux_1_8_registered
`default_nettype wire
